// File: rtl/vertical_scale_factor_control.sv
// Converts front-panel up/down scale requests into per-channel one-hot "times 8" scale factors,
// with press detection, hold delay and auto-repeat stepping of the latched channel.
`default_nettype none

module vertical_scale_factor_control #(
    parameter int SCALE_FACTOR_SIZE = 10,
    parameter int RESET_EXPONENT    = 3,
    parameter int HOLD_CYCLES       = 25000000,
    parameter int REPEAT_CYCLES     = 5000000
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         channelSelect,
    input  logic                         scaleUp,
    input  logic                         scaleDown,
    output logic [SCALE_FACTOR_SIZE-1:0] verticalScaleFactorTimes8Channel1,
    output logic [SCALE_FACTOR_SIZE-1:0] verticalScaleFactorTimes8Channel2,
    output logic                         scaleChanged
);

    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [SCALE_FACTOR_SIZE-1:0] RESET_FACTOR =
        SCALE_FACTOR_SIZE'(1) << RESET_EXPONENT;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         chan_q, chan_d;
    logic                         dir_down_q, dir_down_d;
    logic                         up_q, up_d;
    logic                         down_q, down_d;
    logic                         hist_valid_q, hist_valid_d;
    logic [SCALE_FACTOR_SIZE-1:0] factor1_q, factor1_d;
    logic [SCALE_FACTOR_SIZE-1:0] factor2_q, factor2_d;
    logic                         changed_q, changed_d;

    logic                         press;
    logic                         held;
    logic                         step;
    logic                         step_chan;
    logic                         step_down;
    logic [SCALE_FACTOR_SIZE-1:0] step_cur;
    logic [SCALE_FACTOR_SIZE-1:0] step_next;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        chan_d       = chan_q;
        dir_down_d   = dir_down_q;
        up_d         = scaleUp;
        down_d       = scaleDown;
        hist_valid_d = 1'b1;
        factor1_d    = factor1_q;
        factor2_d    = factor2_q;
        changed_d    = 1'b0;
        step         = 1'b0;
        step_chan    = chan_q;
        step_down    = dir_down_q;
        step_cur     = '0;
        step_next    = '0;

        // The history only counts once it holds a real sample taken after reset,
        // so a button still held through reset never reads as a fresh press.
        press = hist_valid_q && !up_q && !down_q && (scaleUp ^ scaleDown);
        held  = dir_down_q ? (scaleDown && !scaleUp) : (scaleUp && !scaleDown);

        unique case (state_q)
            ST_IDLE: begin
                if (press) begin
                    step       = 1'b1;
                    step_chan  = channelSelect;
                    step_down  = scaleDown;
                    chan_d     = channelSelect;
                    dir_down_d = scaleDown;
                    cnt_d      = '0;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (!held) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == ((state_q == ST_HOLD) ? HOLD_LAST : REPEAT_LAST)) begin
                    step    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_REPEAT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Factors are kept one-hot and shifted, saturating at either end.
        if (step) begin
            step_cur = step_chan ? factor2_q : factor1_q;
            if (step_down) begin
                step_next = step_cur[0] ? step_cur : (step_cur >> 1);
            end else begin
                step_next = step_cur[SCALE_FACTOR_SIZE-1] ? step_cur : (step_cur << 1);
            end
            if (step_chan) begin
                factor2_d = step_next;
            end else begin
                factor1_d = step_next;
            end
            changed_d = (step_next != step_cur);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            chan_q       <= 1'b0;
            dir_down_q   <= 1'b0;
            up_q         <= 1'b0;
            down_q       <= 1'b0;
            hist_valid_q <= 1'b0;
            factor1_q    <= RESET_FACTOR;
            factor2_q    <= RESET_FACTOR;
            changed_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            chan_q       <= chan_d;
            dir_down_q   <= dir_down_d;
            up_q         <= up_d;
            down_q       <= down_d;
            hist_valid_q <= hist_valid_d;
            factor1_q    <= factor1_d;
            factor2_q    <= factor2_d;
            changed_q    <= changed_d;
        end
    end

    assign verticalScaleFactorTimes8Channel1 = factor1_q;
    assign verticalScaleFactorTimes8Channel2 = factor2_q;
    assign scaleChanged                      = changed_q;

endmodule

`default_nettype wire

// File: tb/tb_vertical_scale_factor_control.sv
// Directed bench for vertical_scale_factor_control with short hold/repeat timing.
`default_nettype none

module tb_vertical_scale_factor_control;

    logic       clock;
    logic       reset_n;
    logic       channel_select;
    logic       scale_up;
    logic       scale_down;
    logic [9:0] ch1;
    logic [9:0] ch2;
    logic       scale_changed;

    int checks = 0;
    int errors = 0;

    vertical_scale_factor_control #(
        .SCALE_FACTOR_SIZE(10),
        .RESET_EXPONENT   (3),
        .HOLD_CYCLES      (4),
        .REPEAT_CYCLES    (2)
    ) dut (
        .clock                            (clock),
        .reset_n                          (reset_n),
        .channelSelect                    (channel_select),
        .scaleUp                          (scale_up),
        .scaleDown                        (scale_down),
        .verticalScaleFactorTimes8Channel1(ch1),
        .verticalScaleFactorTimes8Channel2(ch2),
        .scaleChanged                     (scale_changed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; channel_select = 1'b0; scale_up = 1'b0; scale_down = 1'b0;
        tick(); tick();
        checks++; if (ch1 !== 10'd8) begin errors++; $display("FAIL reset_ch1: got %0d expected 8", ch1); end
        checks++; if (ch2 !== 10'd8) begin errors++; $display("FAIL reset_ch2: got %0d expected 8", ch2); end
        checks++; if (scale_changed !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b expected 0", scale_changed); end
        reset_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_single_press();
        channel_select = 1'b0; scale_up = 1'b1;
        tick();
        checks++; if (ch1 !== 10'd16) begin errors++; $display("FAIL press_ch1: got %0d expected 16", ch1); end
        checks++; if (ch2 !== 10'd8) begin errors++; $display("FAIL press_ch2: got %0d expected 8", ch2); end
        checks++; if (scale_changed !== 1'b1) begin errors++; $display("FAIL press_pulse: got %b expected 1", scale_changed); end
        scale_up = 1'b0;
        tick();
        checks++; if (scale_changed !== 1'b0) begin errors++; $display("FAIL press_pulse_end: got %b expected 0", scale_changed); end
        checks++; if (ch1 !== 10'd16) begin errors++; $display("FAIL press_ch1_hold: got %0d expected 16", ch1); end
        tick();
    endtask

    task automatic test_hold_down_saturate();
        logic [9:0] exp_ch2;
        logic       exp_sc;
        int         pulses;
        pulses = 0;
        channel_select = 1'b1; scale_down = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            exp_ch2 = (t <= 4) ? 10'd4 : (t <= 6) ? 10'd2 : 10'd1;
            exp_sc  = (t == 1) || (t == 5) || (t == 7);
            if (scale_changed === 1'b1) pulses++;
            checks++; if (ch2 !== exp_ch2) begin errors++; $display("FAIL hold_down_ch2 t=%0d: got %0d expected %0d", t, ch2, exp_ch2); end
            checks++; if (scale_changed !== exp_sc) begin errors++; $display("FAIL hold_down_pulse t=%0d: got %b expected %b", t, scale_changed, exp_sc); end
            checks++; if (ch1 !== 10'd16) begin errors++; $display("FAIL hold_down_ch1 t=%0d: got %0d expected 16", t, ch1); end
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL hold_down_pulse_count: got %0d expected 3", pulses); end
        scale_down = 1'b0;
        tick(); tick();
    endtask

    task automatic test_hold_up_saturate();
        int         e;
        int         ne;
        logic [9:0] exp_ch1;
        logic       exp_sc;
        e = 4;
        channel_select = 1'b0; scale_up = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            tick();
            exp_sc = 1'b0;
            if (t == 1 || (t >= 5 && (t % 2) == 1)) begin
                ne = (e < 9) ? e + 1 : 9;
                exp_sc = (ne != e);
                e = ne;
            end
            exp_ch1 = 10'd1 << e;
            checks++; if (ch1 !== exp_ch1) begin errors++; $display("FAIL hold_up_ch1 t=%0d: got %0d expected %0d", t, ch1, exp_ch1); end
            checks++; if (scale_changed !== exp_sc) begin errors++; $display("FAIL hold_up_pulse t=%0d: got %b expected %b", t, scale_changed, exp_sc); end
            checks++; if (ch2 !== 10'd1) begin errors++; $display("FAIL hold_up_ch2 t=%0d: got %0d expected 1", t, ch2); end
        end
        scale_up = 1'b0;
        tick(); tick();
    endtask

    task automatic test_conflict();
        channel_select = 1'b1; scale_up = 1'b1; scale_down = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            tick();
            checks++; if (ch2 !== 10'd1 || scale_changed !== 1'b0) begin errors++; $display("FAIL both_pressed t=%0d: got ch2=%0d pulse=%b expected ch2=1 pulse=0", t, ch2, scale_changed); end
        end
        scale_up = 1'b0; scale_down = 1'b0;
        tick(); tick();
        scale_up = 1'b1;
        tick();
        checks++; if (ch2 !== 10'd2 || scale_changed !== 1'b1) begin errors++; $display("FAIL conflict_press: got ch2=%0d pulse=%b expected ch2=2 pulse=1", ch2, scale_changed); end
        tick(); tick();
        scale_down = 1'b1;
        tick();
        scale_down = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            checks++; if (ch2 !== 10'd2 || scale_changed !== 1'b0) begin errors++; $display("FAIL conflict_abort t=%0d: got ch2=%0d pulse=%b expected ch2=2 pulse=0", t, ch2, scale_changed); end
        end
        scale_up = 1'b0;
        tick();
        scale_up = 1'b1;
        tick();
        checks++; if (ch2 !== 10'd4 || scale_changed !== 1'b1) begin errors++; $display("FAIL conflict_repress: got ch2=%0d pulse=%b expected ch2=4 pulse=1", ch2, scale_changed); end
        scale_up = 1'b0;
        tick(); tick();
    endtask

    task automatic test_channel_isolation();
        int         e;
        logic [9:0] exp_ch2;
        e = 2;
        channel_select = 1'b1; scale_up = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            if (t == 6) channel_select = 1'b0;
            tick();
            if (t == 1 || (t >= 5 && (t % 2) == 1)) e = e + 1;
            exp_ch2 = 10'd1 << e;
            checks++; if (ch2 !== exp_ch2) begin errors++; $display("FAIL isolation_ch2 t=%0d: got %0d expected %0d", t, ch2, exp_ch2); end
            checks++; if (ch1 !== 10'd512) begin errors++; $display("FAIL isolation_ch1 t=%0d: got %0d expected 512", t, ch1); end
        end
        scale_up = 1'b0;
        tick(); tick();
    endtask

    task automatic test_reset_mid_repeat();
        channel_select = 1'b0; scale_down = 1'b1;
        repeat (11) tick();
        checks++; if (ch1 !== 10'd16) begin errors++; $display("FAIL setup_ch1: got %0d expected 16", ch1); end
        scale_down = 1'b0;
        tick(); tick();
        scale_up = 1'b1;
        repeat (5) tick();
        checks++; if (ch1 !== 10'd64) begin errors++; $display("FAIL repeat_ch1: got %0d expected 64", ch1); end
        tick();
        reset_n = 1'b0;
        #1;
        checks++; if (ch1 !== 10'd8 || ch2 !== 10'd8) begin errors++; $display("FAIL async_reset: got ch1=%0d ch2=%0d expected 8 8", ch1, ch2); end
        checks++; if (scale_changed !== 1'b0) begin errors++; $display("FAIL async_reset_pulse: got %b expected 0", scale_changed); end
        tick(); tick();
        reset_n = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            checks++; if (ch1 !== 10'd8 || scale_changed !== 1'b0) begin errors++; $display("FAIL held_through_reset t=%0d: got ch1=%0d pulse=%b expected ch1=8 pulse=0", t, ch1, scale_changed); end
        end
        scale_up = 1'b0;
        tick();
        scale_up = 1'b1;
        tick();
        checks++; if (ch1 !== 10'd16 || scale_changed !== 1'b1) begin errors++; $display("FAIL press_after_reset: got ch1=%0d pulse=%b expected ch1=16 pulse=1", ch1, scale_changed); end
        checks++; if (ch2 !== 10'd8) begin errors++; $display("FAIL press_after_reset_ch2: got %0d expected 8", ch2); end
        scale_up = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_hold_down_saturate();
        test_hold_up_saturate();
        test_conflict();
        test_channel_isolation();
        test_reset_mid_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
